load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 TIMEOUT, default 16, cycles without mem_ack before abort; range 1..255.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  core presents a load/store.
REQ-006 req_ready  out  1  unit accepts request this cycle; high only in IDLE with rst low.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-009 req_addr  in  XLEN  byte address (rs1 + immediate, already summed).
REQ-010 req_wdata  in  XLEN  store data, right-justified.
REQ-011 mem_req  out  1  memory access pending; held until mem_ack.
REQ-012 mem_we  out  1  write strobe.
REQ-013 mem_addr  out  XLEN  address with low log2(XLEN/8) bits zeroed.
REQ-014 mem_be  out  XLEN/8  byte-lane enables.
REQ-015 mem_wdata  out  XLEN  lane-replicated store data.
REQ-016 mem_ack  in  1  memory completes; mem_rdata valid this cycle.
REQ-017 mem_rdata  in  XLEN  full-width read word.
REQ-018 rsp_valid  out  1  one-cycle completion pulse.
REQ-019 rsp_rdata  out  XLEN  extended load result; 0 for stores and errors.
REQ-020 rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted legal aligned request; ACCESS->RESP on mem_ack or timeout; RESP->IDLE unconditionally.
REQ-022 Accepted misaligned or illegal request goes IDLE->RESP directly; mem_req never asserted.
REQ-023 Misaligned: H with addr[0]=1; W/WU with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-024 Illegal: funct3 011/110 when XLEN=32; 111 always; loads 1xx with req_we=1.
REQ-025 mem_req/mem_we/mem_addr/mem_be/mem_wdata registered at acceptance, stable throughout ACCESS.
REQ-026 Latency: request accepted cycle N, mem_req high N+1, mem_ack cycle M, rsp_valid high M+1 exactly one cycle.
REQ-027 Load result: selected lanes shifted to bit 0; B/H/W sign-extended to XLEN; BU/HU/WU zero-extended.
REQ-028 mem_ack in same cycle mem_req first rises is legal and completes.
REQ-029 mem_ack outside ACCESS ignored; req_valid outside IDLE ignored, not queued.
REQ-030 Back-to-back: next request accepted earliest in cycle after RESP.

Reset
REQ-031 rst high at clock edge: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 00, timeout counter 0.
REQ-032 Reset mid-ACCESS abandons the access without response; later mem_ack ignored.

Configuration
REQ-033 LSU_TIMEOUT_EN defined: 8-bit counter increments each ACCESS cycle without ack; on reaching TIMEOUT, mem_req drops, RESP with rsp_err 11.
REQ-034 LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; code 11 never produced.

Structure
REQ-035 Package lsu_pkg holds funct3 encodings, FSM state enum, rsp_err codes.
REQ-036 Combinational sub-module lsu_align: byte-enable generation, store lane replication, load lane extraction and extension; unit instantiates it once.

Verification
REQ-037 XLEN=32, SB addr 0x103 wdata 0xAB, ack after 2 cycles -> mem_addr 0x100, mem_be 1000, mem_wdata 0xABABABAB, rsp_err 00.
REQ-038 LB addr 0x101, mem_rdata 0x0000_8000 -> rsp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-039 LW addr 0x102 -> mem_req stays 0, rsp_valid next cycle, rsp_err 01; funct3 111 -> rsp_err 10.
REQ-040 LSU_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req high 4 cycles, rsp_err 11, rsp_rdata 0.
REQ-041 rst asserted during ACCESS, then mem_ack -> no rsp_valid, req_ready 1 after rst drops.
REQ-042 XLEN=64, LWU addr 0x4, mem_rdata 0xFFFF_FFFF_0000_0000 -> rsp_rdata 0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM states and response codes for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store lane replication, load lane extraction/extension
module lsu_align #(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] shifted;
  logic            sign_bit;

  assign shifted = rdata >> {offset, 3'b000};
  assign be      = size_mask << offset;

  // funct3[1:0] is the access size, funct3[2] selects zero extension
  always_comb begin
    size_mask = '0;
    low_mask  = '0;
    wdata_rep = wdata;
    sign_bit  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        size_mask[0]  = 1'b1;
        low_mask[7:0] = '1;
        wdata_rep     = {NB{wdata[7:0]}};
        sign_bit      = shifted[7];
      end
      2'b01: begin
        size_mask[1:0] = '1;
        low_mask[15:0] = '1;
        wdata_rep      = {(NB/2){wdata[15:0]}};
        sign_bit       = shifted[15];
      end
      2'b10: begin
        size_mask[3:0] = '1;
        low_mask[31:0] = '1;
        wdata_rep      = {(NB/4){wdata[31:0]}};
        sign_bit       = shifted[31];
      end
      default: begin
        size_mask = '1;
        low_mask  = '1;
        wdata_rep = wdata;
        sign_bit  = shifted[XLEN-1];
      end
    endcase
    if (funct3[2]) sign_bit = 1'b0;
    rdata_ext = (shifted & low_mask) | (sign_bit ? ~low_mask : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit; LSU_TIMEOUT_EN enables the access timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT must be 1..255");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("load_store_unit: XLEN must be 32 or 64");
  end

  lsu_state_t      state, state_next;
  logic [2:0]      funct3_q;
  logic [OW-1:0]   offset_q;
  logic [2:0]      align_funct3;
  logic [OW-1:0]   align_offset;
  logic [NB-1:0]   align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_rdata;
  logic            accept, illegal, misaligned, timeout_hit;
  logic [1:0]      req_err;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
              ((XLEN == 32) && (req_funct3 == F3_D || req_funct3 == F3_WU));
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W, F3_WU: misaligned = (req_addr[1:0] != 2'b00);
      F3_D:        misaligned = (req_addr[2:0] != 3'b000);
      default:     misaligned = 1'b0;
    endcase
    req_err = illegal ? ERR_ILLEGAL : (misaligned ? ERR_MISALIGN : ERR_OK);
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] timeout_cnt;

  assign timeout_hit = !mem_ack && (timeout_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ST_ACCESS) timeout_cnt <= '0;
    else if (!mem_ack)             timeout_cnt <= timeout_cnt + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Aligner sees the live request in IDLE and the captured access while waiting for ack
  assign align_funct3 = (state == ST_ACCESS) ? funct3_q : req_funct3;
  assign align_offset = (state == ST_ACCESS) ? offset_q : req_addr[OW-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (align_funct3),
    .offset    (align_offset),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (align_be),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = (req_err == ERR_OK) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (mem_ack || timeout_hit) state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
      funct3_q  <= '0;
      offset_q  <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          funct3_q <= req_funct3;
          offset_q <= req_addr[OW-1:0];
          if (req_err == ERR_OK) begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= req_addr & ~(XLEN'(NB - 1));
            mem_be    <= align_be;
            mem_wdata <= align_wdata;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rsp_rdata <= '0;
          end
        end
        ST_ACCESS: if (mem_ack || timeout_hit) begin
          mem_req   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= mem_ack ? ERR_OK : ERR_TIMEOUT;
          rsp_rdata <= (mem_ack && !mem_we) ? align_rdata : '0;
        end
        default: ;
      endcase
    end
  end

endmodule
